cover_toggle_collector: RTL and testbench

//  Parametrised toggle-coverage collector: watches WIDTH toggle-event bits.

---
 rtl/cover_toggle_collector.sv | 102 ++++++++++
 tb/tb_cover_toggle_collector.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: records the first hit of each monitored bit and
// streams each newly covered point once, as a global cover index, over valid/ready.

module cover_toggle_cell (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic hit,
    input  logic grant,
    output logic pending
);
    logic seen;

    // A granted bit is always already seen, so hit and grant never collide here.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            seen    <= 1'b0;
            pending <= 1'b0;
        end else begin
            seen    <= seen | hit;
            pending <= (pending & ~grant) | (hit & ~seen);
        end
    end
endmodule

module cover_toggle_collector #(
    parameter int WIDTH       = 130,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 8940,
    parameter int IDX_W       = 64,
    parameter int CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] valid,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [CNT_W-1:0] reported_count,
    output logic             all_reported
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH < 1) begin : g_width_err
        $error("cover_toggle_collector: WIDTH must be >= 1");
    end
    if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_err
        $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
    end

    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] grant;
    logic [IW-1:0]    gidx;
    logic             grant_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        cover_toggle_cell u_cell (
            .clock   (clock),
            .reset   (reset),
            .clear   (clear),
            .hit     (valid[i]),
            .grant   (grant[i]),
            .pending (pending[i])
        );
    end

    // Isolate the lowest pending bit; the output slot must be free or draining.
    always_comb begin
        grant_en = (!out_valid || out_ready) && (|pending);
        grant    = grant_en ? (pending & (~pending + WIDTH'(1))) : '0;
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (grant[i]) gidx = gidx | IW'(i);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            out_valid <= 1'b0;
            out_index <= '0;
        end else if (grant_en) begin
            out_valid <= 1'b1;
            out_index <= IDX_W'(COVER_INDEX) + IDX_W'(gidx);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            reported_count <= '0;
        end else if (out_valid && out_ready) begin
            reported_count <= reported_count + CNT_W'(1);
        end
    end

    assign all_reported = (reported_count == CNT_W'(WIDTH));
endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed and random bench for cover_toggle_collector, checked every cycle
// against a set-based model plus hand-computed literal expectations.

module tb_cover_toggle_collector;
    localparam int W  = 130;
    localparam int CI = 100;
    localparam int IW = 64;
    localparam int CW = $clog2(W + 1);

    logic          clock = 1'b0;
    logic          reset, clear, out_ready;
    logic [W-1:0]  valid;
    logic          out_valid, all_reported;
    logic [IW-1:0] out_index;
    logic [CW-1:0] reported_count;

    cover_toggle_collector #(
        .WIDTH(W), .COVER_INDEX(CI), .COVER_TOTAL(8940), .IDX_W(IW)
    ) dut (
        .clock(clock), .reset(reset), .valid(valid), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .reported_count(reported_count), .all_reported(all_reported)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Model: sets of hit / queued points, one output slot, an accept counter.
    logic [W-1:0]  m_seen = '0, m_pend = '0, hit_set = '0, rep_set = '0;
    logic          m_v = 1'b0;
    logic [IW-1:0] m_i = '0;
    int            m_cnt = 0;
    logic          s_v = 1'b0;
    logic [IW-1:0] s_i = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic tick();
        int   gi;
        logic acc;
        @(posedge clock);
        if (reset || clear) begin
            m_seen = '0; m_pend = '0; hit_set = '0; rep_set = '0;
            m_v = 1'b0; m_i = '0; m_cnt = 0;
        end else begin
            if (s_v && out_ready) begin
                if (s_i >= IW'(CI) && s_i < IW'(CI + W)) begin
                    chk("unique_report", 64'(rep_set[s_i - IW'(CI)]), 64'd0);
                    rep_set[s_i - IW'(CI)] = 1'b1;
                end else begin
                    chk("index_range", s_i, IW'(CI));
                end
            end
            acc = m_v && out_ready;
            gi = -1;
            if (!m_v || out_ready)
                for (int i = W - 1; i >= 0; i--) if (m_pend[i]) gi = i;
            if (acc) m_cnt++;
            if (gi >= 0) m_pend[gi] = 1'b0;
            m_pend = m_pend | (valid & ~m_seen);
            if (gi >= 0) begin m_v = 1'b1; m_i = IW'(CI + gi); end
            else if (acc) m_v = 1'b0;
            m_seen  = m_seen | valid;
            hit_set = hit_set | valid;
        end
        @(negedge clock);
        chk("out_valid", 64'(out_valid), 64'(m_v));
        chk("out_index", out_index, m_i);
        chk("reported_count", 64'(reported_count), 64'(m_cnt));
        chk("all_reported", 64'(all_reported), 64'(m_cnt == W));
        s_v = out_valid;
        s_i = out_index;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    initial begin
        valid = '0; clear = 1'b0; out_ready = 1'b0; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_index", out_index, 64'd0);
        chk("rst_count", 64'(reported_count), 64'd0);
        chk("rst_all_reported", 64'(all_reported), 64'd0);

        // 1: single hit, two-cycle latency
        out_ready = 1'b1;
        valid[5] = 1'b1; tick(); valid = '0;
        chk("t1_not_yet", 64'(out_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_index", out_index, 64'd105);
        tick();
        chk("t1_count", 64'(reported_count), 64'd1);

        // 2: all bits at once drain one per cycle in index order
        do_clear();
        valid = '1; tick(); valid = '0;
        chk("t2_first_gap", 64'(out_valid), 64'd0);
        for (int k = 0; k < W; k++) begin
            tick();
            chk("t2_seq", out_index, 64'(CI + k));
        end
        tick();
        chk("t2_count", 64'(reported_count), 64'(W));
        chk("t2_all_reported", 64'(all_reported), 64'd1);

        // 3: two simultaneous hits under a stall
        do_clear();
        out_ready = 1'b0;
        valid[1] = 1'b1; valid[3] = 1'b1; tick(); valid = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t3_stall_index", out_index, 64'd101);
        end
        out_ready = 1'b1;
        tick();
        chk("t3_second_index", out_index, 64'd103);
        tick();
        chk("t3_count", 64'(reported_count), 64'd2);

        // 4: repeated hits on one bit report once
        do_clear();
        for (int c = 0; c < 20; c++) begin
            valid[7] = (c % 4 == 0);
            tick();
        end
        valid = '0;
        tick(); tick();
        chk("t4_count", 64'(reported_count), 64'd1);

        // 5: clear discards the in-flight index; bit re-reports afterwards
        do_clear();
        out_ready = 1'b0;
        valid[2] = 1'b1; valid[9] = 1'b1; tick(); valid = '0;
        tick();
        chk("t5_presented", out_index, 64'd102);
        do_clear();
        chk("t5_cleared_valid", 64'(out_valid), 64'd0);
        chk("t5_cleared_count", 64'(reported_count), 64'd0);
        out_ready = 1'b1;
        valid[2] = 1'b1; tick(); valid = '0;
        tick();
        chk("t5_rehit_index", out_index, 64'd102);
        tick();
        chk("t5_rehit_count", 64'(reported_count), 64'd1);

        // 6: reset during a stall, then random traffic
        do_clear();
        out_ready = 1'b0;
        valid[0] = 1'b1; tick(); valid = '0;
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_index", out_index, 64'd0);
        chk("t6_rst_count", 64'(reported_count), 64'd0);
        for (int c = 0; c < 10000; c++) begin
            valid = '0;
            if ($urandom_range(3) == 0) valid[$urandom_range(W - 1)] = 1'b1;
            if ($urandom_range(3) == 0) valid[$urandom_range(W - 1)] = 1'b1;
            out_ready = ($urandom_range(2) != 0);
            tick();
        end
        valid = '0; out_ready = 1'b1;
        for (int c = 0; c < W + 5; c++) tick();
        chk("t6_set_equal", 64'(rep_set == hit_set), 64'd1);
        chk("t6_count_vs_hits", 64'(reported_count), 64'($countones(hit_set)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
